// File: rtl/number_cruncher_n.sv
// number_cruncher_n: parametrised two-cycle accumulator CPU (A, B, O, carry) with run/step control.
// Optional retired-instruction counter enabled by defining NUMBER_CRUNCHER_N_RETIRE_CNT_EN.
module number_cruncher_n #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  localparam int IMM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W,
  localparam int INSTR_W = IMM_W + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] op_code_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [DATA_W-1:0]  reg_o,
  output logic               carry_o,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] D_A    = 2'b00;
  localparam logic [1:0] D_B    = 2'b01;
  localparam logic [1:0] D_O    = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  o_q, o_d;
  logic               carry_q, carry_d;
  logic [INSTR_W-1:0] op_q, op_d;
  logic               step_mode_q, step_mode_d;
  logic               busy_q, halted_q;

  logic               f_j, f_c, f_s, f_sub;
  logic [1:0]         f_dst;
  logic [IMM_W-1:0]   f_imm;
  logic               is_halt;
  logic [DATA_W-1:0]  b_operand;
  logic [DATA_W:0]    alu_sum;
  logic [DATA_W-1:0]  wr_val;
  logic [ADDR_W-1:0]  pc_inc;

  assign f_j     = imem_data[INSTR_W-1];
  assign f_c     = imem_data[INSTR_W-2];
  assign f_dst   = imem_data[INSTR_W-3:INSTR_W-4];
  assign f_s     = imem_data[INSTR_W-5];
  assign f_sub   = imem_data[INSTR_W-6];
  assign f_imm   = imem_data[IMM_W-1:0];
  assign is_halt = f_j & f_c;

  // Subtraction is A + ~B + 1, so the carry out doubles as "no borrow".
  assign b_operand = f_sub ? ~b_q : b_q;
  assign alu_sum   = {1'b0, a_q} + {1'b0, b_operand} + {{DATA_W{1'b0}}, f_sub};
  assign wr_val    = f_s ? f_imm[DATA_W-1:0] : alu_sum[DATA_W-1:0];
  assign pc_inc    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state logic for the control FSM and the architectural registers.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    o_d         = o_q;
    carry_d     = carry_q;
    op_d        = op_q;
    step_mode_d = step_mode_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b1;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        op_d = imem_data;
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          case (f_dst)
            D_A:     a_d = wr_val;
            D_B:     b_d = wr_val;
            D_O:     o_d = a_q;
            default: o_d = o_q;
          endcase
          if (!f_s && ((f_dst == D_A) || (f_dst == D_B))) begin
            carry_d = alu_sum[DATA_W];
          end else begin
            carry_d = carry_q;
          end
          // Conditional jump tests the flag as it stood before this instruction.
          if (f_j && !f_c) begin
            pc_d = f_imm[ADDR_W-1:0];
          end else if (!f_j && f_c && carry_q) begin
            pc_d = f_imm[ADDR_W-1:0];
          end else begin
            pc_d = pc_inc;
          end
          if (step_mode_q || !run) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register update; reset overrides any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= {ADDR_W{1'b0}};
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      o_q         <= {DATA_W{1'b0}};
      carry_q     <= 1'b0;
      op_q        <= {INSTR_W{1'b0}};
      step_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      o_q         <= o_d;
      carry_q     <= carry_d;
      op_q        <= op_d;
      step_mode_q <= step_mode_d;
      busy_q      <= (state_d == ST_FETCH) || (state_d == ST_EXEC);
      halted_q    <= (state_d == ST_HALT);
    end
  end

`ifdef NUMBER_CRUNCHER_N_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counter advances once per EXEC cycle, HALT included, wrapping naturally.
  always_comb begin
    if (state_q == ST_EXEC) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = 16'd0;
`endif

  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign reg_o     = o_q;
  assign carry_o   = carry_q;
  assign op_code_o = op_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
